branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  ID-stage branch sequencer for the MIPS pipeline. Holds a decoded branch in ID
//  until its source registers are safe to read, then drives the branch comparator
//  (bcp code in, Zero out) and issues the PC redirect. Also keeps branch stats and
//  a stall watchdog. Stall/redirect feed the hazard unit and the PC mux.
// PARAMETERS
//  CNT_W      16  width of the saturating statistics counters
//  MAX_STALL  8   consecutive stall cycles before hang_err is set (1..2^CNT_W-1)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  br_valid     in   1   ID holds a branch instruction
//  br_bcp       in   3   compare code: 000 eq, 001 ne, 010 <=0, 011 >0, 100 <0, 101 >=0
//  br_rs        in   5   rs register number
//  br_rt        in   5   rt register number
//  br_uses_rt   in   1   1 when compare reads rt (eq/ne only)
//  br_target    in   32  computed branch target
//  ex_wr/ex_wa  in   1/5 EX-stage instr writes GPR ex_wa
//  mem_wr/mem_wa in  1/5 MEM-stage instr writes GPR mem_wa
//  mem_ready    in   1   MEM result forwardable to ID (0 for loads)
//  cmp_zero     in   1   comparator result for cmp_bcp on forwarded RD1/RD2
//  cmp_bcp      out  3   compare code to comparator
//  stall        out  1   freeze PC/IF/ID, insert bubble into EX
//  redirect     out  1   PC := redirect_pc at next edge
//  redirect_pc  out  32  branch target
//  bad_bcp      out  1   sticky: branch seen with code 110/111
//  hang_err     out  1   sticky: watchdog expired
//  br_cnt       out  CNT_W  branches resolved (saturating)
//  taken_cnt    out  CNT_W  branches taken (saturating)
// BEHAVIOUR
//  Reset: state IDLE; stall_cnt, br_cnt, taken_cnt, bad_bcp, hang_err = 0.
//   Combinational outputs at reset: stall=0, redirect=0, redirect_pc=0, cmp_bcp=000.
//  Hazard hz (combinational), with m(a) = (a!=0)&&(a==br_rs || (br_uses_rt&&a==br_rt)):
//   hz = br_valid && ((ex_wr && m(ex_wa)) || (mem_wr && !mem_ready && m(mem_wa))).
//   EX results are never forwarded to ID; MEM results only when mem_ready=1.
//  cmp_bcp = br_bcp whenever br_valid, else 000.
//  FSM states: IDLE, STALL.
//   IDLE: br_valid && hz -> STALL, stall=1, stall_cnt=1.
//         br_valid && !hz -> resolve this cycle, remain IDLE.
//   STALL: hz re-evaluated every cycle on live EX/MEM inputs (EX advances, bubble).
//         hz -> stay, stall=1, stall_cnt++ (saturating at MAX_STALL).
//         !hz && br_valid -> resolve this cycle, -> IDLE, stall_cnt=0.
//         !br_valid (external flush) -> IDLE, stall_cnt=0, no resolve, no count.
//  stall = hz (Mealy); asserted in the first hazard cycle, not one cycle late.
//  Resolve cycle: stall=0; redirect = cmp_zero && legal(br_bcp); redirect_pc = br_target
//   while br_valid (else 0); br_cnt += 1, taken_cnt += redirect, both saturate at all-ones.
//   Delay slot is not flushed; the slot instr in IF proceeds normally.
//  Illegal bcp (110/111): treated as not taken, still counted in br_cnt, bad_bcp:=1.
//  Watchdog: when stall_cnt reaches MAX_STALL with hz still 1, hang_err:=1 (sticky);
//   stall continues to follow hz. Only reset clears bad_bcp/hang_err.
//  Back-to-back branches: a branch resolving in cycle n and a new br_valid in n+1
//   are independent; no dead cycle required.
//  Reset mid-STALL: returns to IDLE next edge, stall deasserts, counters cleared.
// TESTING
//  1 beq $1,$2 no hazard, cmp_zero=1, target 0x3010 -> same cycle redirect=1,
//    redirect_pc=0x3010, stall=0, br_cnt=1, taken_cnt=1.
//  2 bne $3,$4 with EX writing $4 -> stall=1 one cycle; next cycle ex_wr=0,
//    cmp_zero=0 -> redirect=0, br_cnt=1, taken_cnt=0.
//  3 blez $5 after lw $5 (EX then MEM mem_ready=0) -> stall 2 cycles, resolves in 3rd;
//    lw to $0 or rt-match with br_uses_rt=0 -> no stall.
//  4 bcp=111, cmp_zero=1 -> redirect=0, bad_bcp=1 and stays 1 until reset.
//  5 hazard held 8 cycles (MAX_STALL=8) -> hang_err=1 after 8th stall cycle;
//    reset asserted mid-STALL -> next cycle stall=0, all counters/flags 0.
//  6 CNT_W=4: 20 taken branches -> br_cnt=taken_cnt=15 (saturated, no wrap).

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch sequencer: holds a branch until its sources are forwardable, then resolves and redirects.
// Latency: resolve/redirect are combinational in the first hazard-free cycle; stats and flags update at the next edge.
// Backpressure: stall follows the live hazard (Mealy) and holds PC/IF/ID; an external flush (br_valid=0) abandons the branch.
module branch_resolve_ctrl #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic [2:0]       br_bcp,
    input  logic [4:0]       br_rs,
    input  logic [4:0]       br_rt,
    input  logic             br_uses_rt,
    input  logic [31:0]      br_target,
    input  logic             ex_wr,
    input  logic [4:0]       ex_wa,
    input  logic             mem_wr,
    input  logic [4:0]       mem_wa,
    input  logic             mem_ready,
    input  logic             cmp_zero,
    output logic [2:0]       cmp_bcp,
    output logic             stall,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             bad_bcp,
    output logic             hang_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;
    logic               bad_bcp_q, bad_bcp_d;
    logic               hang_err_q, hang_err_d;

    logic               ex_hit;
    logic               mem_hit;
    logic               hz;
    logic               resolve;
    logic               bcp_legal;

    // Source-register hazard: EX never forwards to ID, MEM only when its result is ready.
    always_comb begin
        ex_hit  = (ex_wa != 5'd0) &&
                  ((ex_wa == br_rs) || (br_uses_rt && (ex_wa == br_rt)));
        mem_hit = (mem_wa != 5'd0) &&
                  ((mem_wa == br_rs) || (br_uses_rt && (mem_wa == br_rt)));
        hz      = br_valid && ((ex_wr && ex_hit) || (mem_wr && !mem_ready && mem_hit));
    end

    // Next-state, stall watchdog, statistics and comparator/PC outputs.
    always_comb begin
        state_d     = IDLE;
        stall_cnt_d = '0;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        bad_bcp_d   = bad_bcp_q;
        hang_err_d  = hang_err_q;

        bcp_legal   = (br_bcp[2:1] != 2'b11);
        resolve     = br_valid && !hz;

        stall       = hz;
        cmp_bcp     = br_valid ? br_bcp : 3'b000;
        redirect_pc = br_valid ? br_target : 32'd0;
        redirect    = resolve && cmp_zero && bcp_legal;

        case (state_q)
            IDLE: begin
                if (hz) begin
                    state_d     = STALL;
                    stall_cnt_d = CNT_ONE;
                end
            end
            STALL: begin
                if (hz) begin
                    state_d     = STALL;
                    stall_cnt_d = (stall_cnt_q >= STALL_LIM) ? STALL_LIM
                                                             : stall_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog fires on the edge that closes the MAX_STALL-th consecutive stall cycle.
        if (hz && (stall_cnt_d == STALL_LIM)) begin
            hang_err_d = 1'b1;
        end

        if (br_valid && !bcp_legal) begin
            bad_bcp_d = 1'b1;
        end

        if (resolve && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + CNT_ONE;
        end
        if (redirect && (taken_cnt_q != CNT_MAX)) begin
            taken_cnt_d = taken_cnt_q + CNT_ONE;
        end
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
            bad_bcp_q   <= 1'b0;
            hang_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            bad_bcp_q   <= bad_bcp_d;
            hang_err_q  <= hang_err_d;
        end
    end

    assign bad_bcp   = bad_bcp_q;
    assign hang_err  = hang_err_q;
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule
